// File: rtl/rdma_ctrl_regs.sv
// ============================================================================
// Module   : rdma_ctrl_regs
// Purpose  : ASHI register bank for the RDMA engine, with a descriptor,
//            a command launch, busy/error status and a completion counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rdma_ctrl_regs #(
   parameter logic [31:0] ID_VALUE = 32'h5244_4D41,
   parameter logic [31:0] MAX_LEN  = 32'h0100_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] ashi_waddr,
   input  logic [31:0] ashi_wdata,
   input  logic        ashi_write,
   output logic        ashi_widle,
   output logic [1:0]  ashi_wresp,
   input  logic [31:0] ashi_raddr,
   input  logic        ashi_read,
   output logic        ashi_ridle,
   output logic [31:0] ashi_rdata,
   output logic [1:0]  ashi_rresp,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [63:0] cmd_src,
   output logic [63:0] cmd_dst,
   output logic [31:0] cmd_len,
   input  logic        xfer_done,
   input  logic        xfer_err
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ACK  = 2'd1,
      W_CMD  = 2'd2
   } wstate_t;

   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_slverr = 2'b10;
   localparam logic [1:0] c_resp_decerr = 2'b11;

   localparam logic [3:0] c_idx_ctrl   = 4'd0;
   localparam logic [3:0] c_idx_src_lo = 4'd1;
   localparam logic [3:0] c_idx_src_hi = 4'd2;
   localparam logic [3:0] c_idx_dst_lo = 4'd3;
   localparam logic [3:0] c_idx_dst_hi = 4'd4;
   localparam logic [3:0] c_idx_length = 4'd5;
   localparam logic [3:0] c_idx_status = 4'd6;
   localparam logic [3:0] c_idx_count  = 4'd7;
   localparam logic [3:0] c_idx_id     = 4'd8;

   wstate_t     r_state;
   logic [31:0] r_src_lo;
   logic [31:0] r_src_hi;
   logic [31:0] r_dst_lo;
   logic [31:0] r_dst_hi;
   logic [31:0] r_length;
   logic [31:0] r_done_count;
   logic        r_busy;
   logic        r_last_err;

   logic [3:0]  w_widx;
   logic [3:0]  w_ridx;
   logic        w_done_hit;
   logic        w_len_ok;
   logic        w_start_ok;
   logic        w_clr;
   logic [31:0] w_rdata;
   logic [1:0]  w_rresp;
   logic        w_unused;

   assign w_widx     = ashi_waddr[5:2];
   assign w_ridx     = ashi_raddr[5:2];
   assign w_done_hit = xfer_done & r_busy;
   assign w_len_ok   = (r_length != 32'd0) && (r_length <= MAX_LEN);
   // A completion arriving in the same cycle frees the engine for a new START.
   assign w_start_ok = w_len_ok & ~(r_busy & ~xfer_done);
   assign w_clr      = ashi_write && (r_state == W_IDLE) && (w_widx == c_idx_ctrl) && ashi_wdata[1];
   assign w_unused   = ^{ashi_waddr[31:6], ashi_waddr[1:0], ashi_raddr[31:6], ashi_raddr[1:0]};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= W_IDLE;
         r_src_lo     <= 32'd0;
         r_src_hi     <= 32'd0;
         r_dst_lo     <= 32'd0;
         r_dst_hi     <= 32'd0;
         r_length     <= 32'd0;
         r_done_count <= 32'd0;
         r_busy       <= 1'b0;
         r_last_err   <= 1'b0;
         ashi_widle   <= 1'b1;
         ashi_wresp   <= c_resp_okay;
         cmd_valid    <= 1'b0;
         cmd_src      <= 64'd0;
         cmd_dst      <= 64'd0;
         cmd_len      <= 32'd0;
      end else begin
         if (w_done_hit) begin
            r_busy     <= 1'b0;
            r_last_err <= xfer_err;
         end

         if (w_clr) begin
            r_done_count <= {31'd0, w_done_hit};
         end else if (w_done_hit) begin
            r_done_count <= r_done_count + 32'd1;
         end

         // An accepted START below overrides busy/last_err from the completion above.
         case (r_state)
            W_IDLE: begin
               if (ashi_write) begin
                  ashi_widle <= 1'b0;
                  ashi_wresp <= c_resp_okay;
                  r_state    <= W_ACK;
                  case (w_widx)
                     c_idx_ctrl: begin
                        if (ashi_wdata[0]) begin
                           if (w_start_ok) begin
                              r_busy     <= 1'b1;
                              r_last_err <= 1'b0;
                              cmd_valid  <= 1'b1;
                              cmd_src    <= {r_src_hi, r_src_lo};
                              cmd_dst    <= {r_dst_hi, r_dst_lo};
                              cmd_len    <= r_length;
                              r_state    <= W_CMD;
                           end else begin
                              ashi_wresp <= c_resp_slverr;
                           end
                        end
                     end
                     c_idx_src_lo: r_src_lo <= ashi_wdata;
                     c_idx_src_hi: r_src_hi <= ashi_wdata;
                     c_idx_dst_lo: r_dst_lo <= ashi_wdata;
                     c_idx_dst_hi: r_dst_hi <= ashi_wdata;
                     c_idx_length: r_length <= ashi_wdata;
                     c_idx_status, c_idx_count, c_idx_id: ashi_wresp <= c_resp_slverr;
                     default: ashi_wresp <= c_resp_decerr;
                  endcase
               end
            end
            W_ACK: begin
               ashi_widle <= 1'b1;
               r_state    <= W_IDLE;
            end
            W_CMD: begin
               if (cmd_ready) begin
                  cmd_valid  <= 1'b0;
                  ashi_wresp <= c_resp_okay;
                  ashi_widle <= 1'b1;
                  r_state    <= W_IDLE;
               end
            end
            default: begin
               ashi_widle <= 1'b1;
               r_state    <= W_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_rdata = 32'd0;
      w_rresp = c_resp_okay;
      case (w_ridx)
         c_idx_ctrl:   w_rdata = 32'd0;
         c_idx_src_lo: w_rdata = r_src_lo;
         c_idx_src_hi: w_rdata = r_src_hi;
         c_idx_dst_lo: w_rdata = r_dst_lo;
         c_idx_dst_hi: w_rdata = r_dst_hi;
         c_idx_length: w_rdata = r_length;
         c_idx_status: w_rdata = {29'd0, r_last_err, cmd_valid, r_busy};
         c_idx_count:  w_rdata = r_done_count;
         c_idx_id:     w_rdata = ID_VALUE;
         default:      w_rresp = c_resp_decerr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ashi_ridle <= 1'b1;
         ashi_rdata <= 32'd0;
         ashi_rresp <= c_resp_okay;
      end else begin
         ashi_ridle <= ~ashi_read;
         if (ashi_read) begin
            ashi_rdata <= w_rdata;
            ashi_rresp <= w_rresp;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rdma_ctrl_regs.sv
// ============================================================================
// Module   : tb_rdma_ctrl_regs
// Purpose  : Directed self-checking bench for rdma_ctrl_regs.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rdma_ctrl_regs;

   localparam logic [31:0] ID_VALUE = 32'h5244_4D41;
   localparam logic [31:0] MAX_LEN  = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] ashi_waddr = 32'd0;
   logic [31:0] ashi_wdata = 32'd0;
   logic        ashi_write = 1'b0;
   logic        ashi_widle;
   logic [1:0]  ashi_wresp;
   logic [31:0] ashi_raddr = 32'd0;
   logic        ashi_read = 1'b0;
   logic        ashi_ridle;
   logic [31:0] ashi_rdata;
   logic [1:0]  ashi_rresp;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [63:0] cmd_src;
   logic [63:0] cmd_dst;
   logic [31:0] cmd_len;
   logic        xfer_done = 1'b0;
   logic        xfer_err = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   rdma_ctrl_regs #(.ID_VALUE(ID_VALUE), .MAX_LEN(MAX_LEN)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ashi_waddr (ashi_waddr),
      .ashi_wdata (ashi_wdata),
      .ashi_write (ashi_write),
      .ashi_widle (ashi_widle),
      .ashi_wresp (ashi_wresp),
      .ashi_raddr (ashi_raddr),
      .ashi_read  (ashi_read),
      .ashi_ridle (ashi_ridle),
      .ashi_rdata (ashi_rdata),
      .ashi_rresp (ashi_rresp),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_src    (cmd_src),
      .cmd_dst    (cmd_dst),
      .cmd_len    (cmd_len),
      .xfer_done  (xfer_done),
      .xfer_err   (xfer_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain write that completes through W_ACK; any done pulse set by the caller lasts one cycle.
   task automatic reg_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] exp_resp);
      ashi_waddr = addr;
      ashi_wdata = data;
      ashi_write = 1'b1;
      tick();
      ashi_write = 1'b0;
      xfer_done  = 1'b0;
      xfer_err   = 1'b0;
      check({tag, " widle0"}, 64'(ashi_widle), 64'd0);
      check({tag, " novalid"}, 64'(cmd_valid), 64'd0);
      tick();
      check({tag, " widle1"}, 64'(ashi_widle), 64'd1);
      check({tag, " wresp"}, 64'(ashi_wresp), 64'(exp_resp));
   endtask

   // Accepted START with cmd_ready already high.
   task automatic start_ok(input string tag);
      ashi_waddr = 32'h0;
      ashi_wdata = 32'h1;
      ashi_write = 1'b1;
      tick();
      ashi_write = 1'b0;
      xfer_done  = 1'b0;
      xfer_err   = 1'b0;
      check({tag, " valid1"}, 64'(cmd_valid), 64'd1);
      check({tag, " widle0"}, 64'(ashi_widle), 64'd0);
      tick();
      check({tag, " valid0"}, 64'(cmd_valid), 64'd0);
      check({tag, " widle1"}, 64'(ashi_widle), 64'd1);
      check({tag, " wresp"}, 64'(ashi_wresp), 64'd0);
   endtask

   task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      ashi_raddr = addr;
      ashi_read  = 1'b1;
      tick();
      ashi_read = 1'b0;
      check({tag, " ridle0"}, 64'(ashi_ridle), 64'd0);
      tick();
      check({tag, " ridle1"}, 64'(ashi_ridle), 64'd1);
      check({tag, " rdata"}, 64'(ashi_rdata), 64'(exp_data));
      check({tag, " rresp"}, 64'(ashi_rresp), 64'(exp_resp));
   endtask

   task automatic pulse_done(input logic err);
      xfer_done = 1'b1;
      xfer_err  = err;
      tick();
      xfer_done = 1'b0;
      xfer_err  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst widle", 64'(ashi_widle), 64'd1);
      check("rst ridle", 64'(ashi_ridle), 64'd1);
      check("rst wresp", 64'(ashi_wresp), 64'd0);
      check("rst rresp", 64'(ashi_rresp), 64'd0);
      check("rst rdata", 64'(ashi_rdata), 64'd0);
      check("rst valid", 64'(cmd_valid), 64'd0);
      check("rst src", cmd_src, 64'd0);
      check("rst len", 64'(cmd_len), 64'd0);
      resetn = 1'b1;
      tick();

      rd_check("id", 32'h20, ID_VALUE, 2'b00);
      rd_check("status0", 32'h18, 32'h0, 2'b00);

      reg_write("src_lo", 32'h04, 32'h1000, 2'b00);
      reg_write("dst_lo", 32'h0C, 32'h2000, 2'b00);
      reg_write("len64", 32'h14, 32'd64, 2'b00);
      rd_check("rb src_lo", 32'h04, 32'h1000, 2'b00);

      // START held off by cmd_ready=0 for five cycles.
      ashi_waddr = 32'h0;
      ashi_wdata = 32'h1;
      ashi_write = 1'b1;
      tick();
      ashi_write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("hold valid", 64'(cmd_valid), 64'd1);
         check("hold widle", 64'(ashi_widle), 64'd0);
         check("hold src", cmd_src, 64'h1000);
         check("hold dst", cmd_dst, 64'h2000);
         check("hold len", 64'(cmd_len), 64'd64);
         tick();
      end
      check("hold widle end", 64'(ashi_widle), 64'd0);
      cmd_ready = 1'b1;
      tick();
      check("hs widle", 64'(ashi_widle), 64'd1);
      check("hs valid", 64'(cmd_valid), 64'd0);
      check("hs wresp", 64'(ashi_wresp), 64'd0);
      rd_check("status busy", 32'h18, 32'h1, 2'b00);

      reg_write("src rewrite", 32'h04, 32'h3000, 2'b00);
      check("inflight src", cmd_src, 64'h1000);
      reg_write("start busy", 32'h00, 32'h1, 2'b10);

      pulse_done(1'b1);
      rd_check("status err", 32'h18, 32'h4, 2'b00);
      rd_check("count1", 32'h1C, 32'd1, 2'b00);

      start_ok("start2");
      check("start2 src", cmd_src, 64'h3000);
      // START coincident with an erroring completion: accepted and last_err cleared.
      xfer_done = 1'b1;
      xfer_err  = 1'b1;
      start_ok("start coinc");
      rd_check("status coinc", 32'h18, 32'h1, 2'b00);
      rd_check("count2", 32'h1C, 32'd2, 2'b00);
      pulse_done(1'b0);

      reg_write("len0", 32'h14, 32'd0, 2'b00);
      reg_write("start len0", 32'h00, 32'h1, 2'b10);
      reg_write("len big", 32'h14, MAX_LEN + 32'd1, 2'b00);
      reg_write("start big", 32'h00, 32'h1, 2'b10);
      reg_write("len max", 32'h14, MAX_LEN, 2'b00);
      start_ok("start max");
      check("max len", 64'(cmd_len), 64'(MAX_LEN));

      reg_write("wr count", 32'h1C, 32'h5, 2'b10);
      rd_check("count3", 32'h1C, 32'd3, 2'b00);
      reg_write("wr unmapped", 32'h30, 32'h5, 2'b11);
      rd_check("rd unmapped", 32'h30, 32'h0, 2'b11);
      rd_check("alias id", 32'hABCD_0062, ID_VALUE, 2'b00);
      rd_check("rd ctrl", 32'h00, 32'h0, 2'b00);

      // CLR_COUNT in the same cycle as a counted completion.
      xfer_done = 1'b1;
      reg_write("clr coinc", 32'h00, 32'h2, 2'b00);
      rd_check("count clr", 32'h1C, 32'd1, 2'b00);
      rd_check("status idle", 32'h18, 32'h0, 2'b00);

      start_ok("start wrap");
      force dut.r_done_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_done_count;
      rd_check("count pre", 32'h1C, 32'hFFFF_FFFF, 2'b00);
      pulse_done(1'b0);
      rd_check("count wrap", 32'h1C, 32'd0, 2'b00);

      // Simultaneous write and read.
      ashi_waddr = 32'h10;
      ashi_wdata = 32'hDEAD;
      ashi_write = 1'b1;
      ashi_raddr = 32'h20;
      ashi_read  = 1'b1;
      tick();
      ashi_write = 1'b0;
      ashi_read  = 1'b0;
      check("sim widle0", 64'(ashi_widle), 64'd0);
      check("sim ridle0", 64'(ashi_ridle), 64'd0);
      tick();
      check("sim rdata", 64'(ashi_rdata), 64'(ID_VALUE));
      check("sim wresp", 64'(ashi_wresp), 64'd0);
      rd_check("rb dst_hi", 32'h10, 32'hDEAD, 2'b00);

      // Reset while a command is pending.
      cmd_ready  = 1'b0;
      ashi_waddr = 32'h0;
      ashi_wdata = 32'h1;
      ashi_write = 1'b1;
      tick();
      ashi_write = 1'b0;
      check("pre rst valid", 64'(cmd_valid), 64'd1);
      resetn = 1'b0;
      tick();
      check("mid rst valid", 64'(cmd_valid), 64'd0);
      check("mid rst widle", 64'(ashi_widle), 64'd1);
      check("mid rst src", cmd_src, 64'd0);
      check("mid rst len", 64'(cmd_len), 64'd0);
      resetn = 1'b1;
      tick();
      rd_check("post status", 32'h18, 32'h0, 2'b00);
      rd_check("post count", 32'h1C, 32'h0, 2'b00);
      rd_check("post src_lo", 32'h04, 32'h0, 2'b00);
      rd_check("post dst_hi", 32'h10, 32'h0, 2'b00);
      rd_check("post length", 32'h14, 32'h0, 2'b00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rdma_ctrl_regs.md
# rdma_ctrl_regs

ASHI handler for the RDMA control register bank. It sits directly downstream of the AXI4-Lite slave and consumes its ASHI write/read requests. It holds the transfer descriptor (source, destination, length) and launches one transfer command at a time to the RDMA engine over a valid/ready command port. It also tracks busy/error status and a completion counter from the engine's done pulse.

## Interface
- ID_VALUE, 32'h5244_4D41, constant returned by the ID register
- MAX_LEN, 32'h0100_0000, largest legal LENGTH in bytes
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ashi_waddr  in  32  write address, valid in the ashi_write cycle
- ashi_wdata  in  32  write data, valid in the ashi_write cycle
- ashi_write  in  1  one-cycle write request
- ashi_widle  out  1  1 = write logic idle, ashi_wresp valid
- ashi_wresp  out  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR
- ashi_raddr  in  32  read address, valid in the ashi_read cycle
- ashi_read  in  1  one-cycle read request
- ashi_ridle  out  1  1 = read logic idle, rdata/rresp valid
- ashi_rdata  out  32  read data
- ashi_rresp  out  2  read response
- cmd_valid  out  1  command valid
- cmd_ready  in  1  engine accepts command
- cmd_src  out  64  source address
- cmd_dst  out  64  destination address
- cmd_len  out  32  length in bytes
- xfer_done  in  1  one-cycle completion pulse from engine
- xfer_err  in  1  error flag, qualified by xfer_done

## Operation
Register map: decode on addr[5:2]; addr[1:0] and addr[31:6] are ignored.
- 0x00 CTRL (WO; reads 0)
  - bit0 START
  - bit1 CLR_COUNT
- 0x04 SRC_LO, RW
- 0x08 SRC_HI, RW
- 0x0C DST_LO, RW
- 0x10 DST_HI, RW
- 0x14 LENGTH, RW
- 0x18 STATUS, RO
  - bit0 busy
  - bit1 cmd_valid
  - bit2 last_err
- 0x1C DONE_COUNT, RO
- 0x20 ID, RO (ID_VALUE)
- 0x24..0x3C unmapped

Write FSM states: W_IDLE, W_ACK, W_CMD.
- W_IDLE, ashi_write=1:
  - Latch the address and data, drop ashi_widle.
  - Decode, then go to W_ACK, or go to W_CMD for a launch.
- Unmapped address: no effect; wresp=DECERR.
- Write to STATUS, DONE_COUNT or ID: no effect; wresp=SLVERR.
- CTRL write, CLR_COUNT: DONE_COUNT<=0, independent of START.
- CTRL write, START rejected if any of these hold: effective busy (busy & ~xfer_done), LENGTH==0, or LENGTH>MAX_LEN.
  - Rejected START: no launch; wresp=SLVERR.
- CTRL write, START accepted:
  - Set busy and cmd_valid, clear last_err.
  - Snapshot the descriptor onto cmd_*; go to W_CMD.
- W_ACK: raise ashi_widle; return to W_IDLE.
- W_CMD: hold cmd_* stable while cmd_valid=1.
  - On cmd_valid & cmd_ready: drop cmd_valid, wresp=OKAY, raise ashi_widle, go to W_IDLE.
- ashi_write outside W_IDLE is ignored.

Read path:
- On ashi_read, drop ashi_ridle for exactly one cycle.
- Register rdata/rresp from ashi_raddr; hold both until the next ashi_read.
- Unmapped address: rdata=0, rresp=DECERR.

Completion:
- xfer_done while busy:
  - busy<=0.
  - last_err<=xfer_err.
  - DONE_COUNT+1, wrapping at 2^32.
- xfer_done while not busy: ignored.
- CLR_COUNT in the same cycle as a counted xfer_done: DONE_COUNT=1.
- Descriptor registers may be rewritten while busy. This does not affect the in-flight cmd_*.

## Timing
- Reset values:
  - ashi_widle=1, ashi_ridle=1.
  - ashi_wresp=00, ashi_rresp=00, ashi_rdata=0.
  - cmd_valid=0, cmd_src/dst/len=0.
  - All registers 0, busy=0, last_err=0.
- Reset mid-W_CMD: cmd_valid drops the next edge with no completion counted.
- Register write latency: ashi_widle is 0 for exactly one cycle after ashi_write.
- START latency:
  - cmd_valid=1 the cycle after ashi_write.
  - ashi_widle stays 0 until the cycle after the cmd handshake.
  - Minimum is 2 cycles with cmd_ready held high.
- Read latency: ashi_ridle is 0 for exactly one cycle after ashi_read; data is valid when it returns to 1.
- Read and write paths are independent; simultaneous requests are both serviced.
- STATUS read in the cycle after the cmd handshake shows bit1=0 and bit0=1.

## Test plan
- After reset, read 0x20 -> rdata=32'h5244_4D41, rresp=00, ridle low one cycle. Read 0x18 -> 0.
- Write SRC_LO=0x1000, DST_LO=0x2000, LENGTH=64, then START.
  - Hold cmd_ready=0 for 5 cycles -> cmd_valid=1 with cmd_src=0x1000, cmd_dst=0x2000, cmd_len=64.
  - ashi_widle stays 0 throughout, then returns to 1 one cycle after the handshake with wresp=00.
- START while busy -> wresp=10, no cmd_valid.
  - Pulse xfer_done with xfer_err=1 -> STATUS=0x4, DONE_COUNT=1.
  - START in the same cycle as xfer_done -> accepted, last_err cleared.
- LENGTH=0, then START -> wresp=10. LENGTH=MAX_LEN+1, then START -> wresp=10. LENGTH=MAX_LEN, then START -> accepted.
- Write 0x1C -> wresp=10, value unchanged. Write and read 0x30 -> DECERR, rdata=0.
- Counter: CLR_COUNT coincident with a counted xfer_done -> DONE_COUNT=1.
  - Preload via 2^32 completions (force) -> wraps to 0.
  - Assert resetn=0 during W_CMD -> cmd_valid=0 and all registers 0 next cycle.
